trit_addr_scanner: RTL and testbench

Sequential, parametrised tri-state address reader for the encoder front end. It scans N address pins with alternating weak pull-up and pull-down and classifies each pin as high, low or float. It also debounces the result over several scans and publishes a registered, validated code. It replaces the purely combinational high/low/float comparator in the encoder path. The comparator could only detect float in simulation; this block detects a floating pad in silicon.

---
 rtl/trit_addr_scanner.sv | 189 ++++++++++++++++++
 tb/tb_trit_addr_scanner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/trit_addr_scanner.sv
// trit_addr_scanner: tri-state address pin reader.
// Alternating weak pulls classify pins as high/low/float, debounced over scans.
module trit_addr_scanner #(
  parameter int N         = 8,
  parameter int SETTLE    = 4,
  parameter int STABLE    = 2,
  parameter int MAX_SCANS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cont,
  input  logic [N-1:0] pin_in,
  output logic         pull_en,
  output logic         pull_sel,
  output logic [N-1:0] A_01,
  output logic [N-1:0] A_F,
  output logic         valid,
  output logic         busy,
  output logic         changed,
  output logic         err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int MW = $clog2(STABLE + 1);
  localparam int SW = $clog2(MAX_SCANS + 1);

  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  localparam logic [MW-1:0] MFULL = MW'(STABLE);
  localparam logic [SW-1:0] SMAX = SW'(MAX_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DN,
    EVAL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] match_q, match_d;
  logic [SW-1:0] scans_q, scans_d;
  logic [N-1:0]  s_up_q, s_up_d;
  logic [N-1:0]  s_dn_q, s_dn_d;
  logic [N-1:0]  cl_q, cl_d;
  logic [N-1:0]  cf_q, cf_d;
  logic [N-1:0]  a01_q, a01_d;
  logic [N-1:0]  af_q, af_d;
  logic          valid_q, valid_d;
  logic          chg_q, chg_d;
  logic          err_q, err_d;

  logic [N-1:0]  lvl, flt;
  logic          bad, same, commit;

  // Per-pin classification of the two pull samples.
  always_comb begin
    lvl  = s_up_q & s_dn_q;
    flt  = s_up_q & ~s_dn_q;
    bad  = |(~s_up_q & s_dn_q);
    same = (lvl == cl_q) && (flt == cf_q);
  end

  // Next-state: pull phase sequencing, debounce and commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    scans_d = scans_q;
    s_up_d  = s_up_q;
    s_dn_d  = s_dn_q;
    cl_d    = cl_q;
    cf_d    = cf_q;
    a01_d   = a01_q;
    af_d    = af_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = UP;
          cnt_d   = '0;
          err_d   = 1'b0;
          scans_d = '0;
          match_d = '0;
        end
      end
      UP: begin
        if (cnt_q == LAST) begin
          s_up_d  = pin_in;
          cnt_d   = '0;
          state_d = DN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DN: begin
        if (cnt_q == LAST) begin
          s_dn_d  = pin_in;
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVAL: begin
        scans_d = scans_q + 1'b1;
        if (bad) begin
          match_d = '0;
          err_d   = 1'b1;
        end else if (same) begin
          if (match_q != MFULL) begin
            match_d = match_q + 1'b1;
            commit  = (match_d == MFULL);
          end
        end else begin
          cl_d    = lvl;
          cf_d    = flt;
          match_d = MW'(1);
          commit  = (match_d == MFULL);
        end
        if (commit) begin
          a01_d   = lvl;
          af_d    = flt;
          valid_d = 1'b1;
          chg_d   = !valid_q || (lvl != a01_q) || (flt != af_q);
          scans_d = '0;
        end
        if (commit && !cont) begin
          state_d = IDLE;
        end else if (!commit && scans_d >= SMAX) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = UP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= '0;
      scans_q <= '0;
      s_up_q  <= '0;
      s_dn_q  <= '0;
      cl_q    <= '0;
      cf_q    <= '0;
      a01_q   <= '0;
      af_q    <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      scans_q <= scans_d;
      s_up_q  <= s_up_d;
      s_dn_q  <= s_dn_d;
      cl_q    <= cl_d;
      cf_q    <= cf_d;
      a01_q   <= a01_d;
      af_q    <= af_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  // Pull controls and status decoded from state.
  always_comb begin
    pull_en  = (state_q == UP) || (state_q == DN);
    pull_sel = (state_q == UP);
    busy     = (state_q != IDLE);
    A_01     = a01_q;
    A_F      = af_q;
    valid    = valid_q;
    changed  = chg_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_trit_addr_scanner.sv
// tb_trit_addr_scanner: vector table plus scoreboard bench
// for the tri-state address scanner (default parameters).
module tb_trit_addr_scanner;

  logic       clk = 1'b0;
  logic       rst, start, cont;
  logic [7:0] pin_in;
  logic       pull_en, pull_sel;
  logic [7:0] A_01, A_F;
  logic       valid, busy, changed, err;

  logic [7:0] drv, fm, im, nz;
  logic       noise_on;
  int         t;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic [7:0] drv, fm, im, nz;
    int         end_t;
    logic [7:0] a01, af;
    logic       err, vld, chg;
  } vec_t;

  typedef struct {
    int         t;
    logic [7:0] a01, af;
    logic       err, vld, chg;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  trit_addr_scanner dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
    .pin_in(pin_in), .pull_en(pull_en), .pull_sel(pull_sel),
    .A_01(A_01), .A_F(A_F), .valid(valid), .busy(busy),
    .changed(changed), .err(err)
  );

  always #5 clk = ~clk;

  // Pad model: driven pins, floats follow the pull, inverted pins oppose it.
  always_comb begin
    pin_in = ((drv ^ (noise_on ? nz : 8'h00)) & ~fm & ~im)
           | (fm & {8{pull_sel}}) | (im & {8{~pull_sel}});
  end

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", nm, act, req, t);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   nchg;
    int   cht;
    drv = v.drv; fm = v.fm; im = v.im; nz = v.nz;
    noise_on = 1'b1;
    sb.push_back('{v.end_t, v.a01, v.af, v.err, v.vld, v.chg});
    start = 1'b1;
    t = -1;
    step();
    start = 1'b0;
    nchg = 0;
    cht = -1;
    while (busy === 1'b1 && t < 200) begin
      chk("pull_en", pull_en, (t % 9) != 8);
      chk("pull_sel", pull_sel, (t % 9) < 4);
      if (changed === 1'b1) begin nchg++; cht = t; end
      step();
      if (t >= 8) noise_on = 1'b0;
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout: busy still %b at t=%0d", busy, t);
    end
    if (changed === 1'b1) begin nchg++; cht = t; end
    e = sb.pop_front();
    chk("done_edge", t, e.t);
    chk("A_01", A_01, e.a01);
    chk("A_F", A_F, e.af);
    chk("err", err, e.err);
    chk("valid", valid, e.vld);
    chk("n_changed", nchg, e.chg ? 1 : 0);
    if (e.chg) chk("changed_edge", cht, e.t);
    step();
    chk("changed_one_cycle", changed, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{8'h00, 8'h00, 8'h04, 8'h00, 144, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 8'h00, 8'h00, 8'h00, 18, 8'hA3, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'h00, 8'h81, 8'h00, 8'h00, 18, 8'h00, 8'h81, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'h55, 8'h00, 8'h00, 8'h08, 27, 8'h55, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h55, 8'h00, 8'h00, 8'h00, 18, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; cont = 1'b0;
    drv = '0; fm = '0; im = '0; nz = '0; noise_on = 1'b0;
    t = 0;
    step();
    step();
    rst = 1'b0;
    chk("rst_pull_en", pull_en, 1'b0);
    chk("rst_pull_sel", pull_sel, 1'b0);
    chk("rst_A_01", A_01, 8'h00);
    chk("rst_A_F", A_F, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_changed", changed, 1'b0);
    chk("rst_err", err, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Continuous mode: commit 0F, then pin 4 floats from t=36.
    drv = 8'h0F; fm = 8'h00; im = 8'h00; nz = 8'h00;
    cont = 1'b1;
    sb.push_back('{18, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1});
    sb.push_back('{54, 8'h0F, 8'h10, 1'b0, 1'b1, 1'b1});
    start = 1'b1;
    t = -1;
    step();
    start = 1'b0;
    while (t < 76) begin
      if (changed === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL cont_extra_changed: pulse at t=%0d want none", t);
        end else begin
          e = sb.pop_front();
          chk("cont_chg_edge", t, e.t);
          chk("cont_A_01", A_01, e.a01);
          chk("cont_A_F", A_F, e.af);
        end
      end
      step();
      if (t == 36) fm = 8'h10;
    end
    chk("cont_pending", sb.size(), 0);
    chk("cont_busy", busy, 1'b1);
    chk("cont_in_dn", {pull_en, pull_sel}, 2'b10);
    chk("cont_valid", valid, 1'b1);

    // Reset in DN after a commit.
    rst = 1'b1;
    step();
    rst = 1'b0;
    cont = 1'b0;
    chk("mid_rst_pull_en", pull_en, 1'b0);
    chk("mid_rst_pull_sel", pull_sel, 1'b0);
    chk("mid_rst_A_01", A_01, 8'h00);
    chk("mid_rst_A_F", A_F, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_changed", changed, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    step();
    chk("post_rst_idle", busy, 1'b0);

    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
